// File: rtl/four_bit_adder_overflow.sv
// four_bit_adder_overflow: signed WIDTH-bit adder with overflow/carry flags and
// registered outputs, built from a ripple chain of full-adder cells.
// Optional feature: define FOUR_BIT_ADDER_OVERFLOW_SAT_EN to clamp the sum on
// signed overflow (overflow and carry_out are reported unchanged).

// One ripple stage.
module four_bit_adder_overflow_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module four_bit_adder_overflow #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             carry_out,
  output logic             out_valid
);
  localparam int STAGES = 1;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic [STAGES:0]  vld_pipe;

  assign c[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      four_bit_adder_overflow_fa u_fa (
        .a  (operand1[i]),
        .b  (operand2[i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf = c[WIDTH-1] ^ c[WIDTH];

`ifdef FOUR_BIT_ADDER_OVERFLOW_SAT_EN
  // On overflow both operands share the sign; clamp toward that sign.
  always_comb begin
    res = s;
    if (ovf) res = operand1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res = s;
`endif

  // Valid tracks capture enables; reset clears it.
  assign vld_pipe[0] = in_valid;
  always_ff @(posedge clk) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end
  assign out_valid = vld_pipe[STAGES];

  // Result registers: load on in_valid, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (in_valid) begin
      sum       <= res;
      overflow  <= ovf;
      carry_out <= c[WIDTH];
    end
  end
endmodule

// File: tb/tb_four_bit_adder_overflow.sv
// Directed bench for four_bit_adder_overflow (WIDTH=4); expectations are
// hand-computed, with clamped sums used when FOUR_BIT_ADDER_OVERFLOW_SAT_EN is set.
module tb_four_bit_adder_overflow;
  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [3:0] operand1, operand2;
  logic [3:0] sum;
  logic       overflow, carry_out, out_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  four_bit_adder_overflow #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .operand1(operand1), .operand2(operand2),
    .sum(sum), .overflow(overflow), .carry_out(carry_out), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at negedge, let one rising edge capture, sample 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst = r; in_valid = v; operand1 = a; operand2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] s_wrap, input logic [3:0] s_sat,
                     input logic ov, input logic cy);
    logic [3:0] s_exp;
`ifdef FOUR_BIT_ADDER_OVERFLOW_SAT_EN
    s_exp = s_sat;
`else
    s_exp = s_wrap;
`endif
    step(1'b0, 1'b1, a, b);
    chk({tag, ".sum"}, {4'b0, sum}, {4'b0, s_exp});
    chk({tag, ".ovf"}, {7'b0, overflow}, {7'b0, ov});
    chk({tag, ".cy"},  {7'b0, carry_out}, {7'b0, cy});
    chk({tag, ".vld"}, {7'b0, out_valid}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; operand1 = '0; operand2 = '0;
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    chk("rst.sum", {4'b0, sum}, 8'h00);
    chk("rst.ovf", {7'b0, overflow}, 8'h00);
    chk("rst.cy",  {7'b0, carry_out}, 8'h00);
    chk("rst.vld", {7'b0, out_valid}, 8'h00);

    //       tag        a        b        wrap     sat      ov    cy
    vec("p5p2",   4'b0101, 4'b0010, 4'b0111, 4'b0111, 1'b0, 1'b0);

    // Hold: results keep their value, valid drops.
    step(1'b0, 1'b0, 4'b1111, 4'b1111);
    chk("hold.sum", {4'b0, sum}, 8'h07);
    chk("hold.ovf", {7'b0, overflow}, 8'h00);
    chk("hold.cy",  {7'b0, carry_out}, 8'h00);
    chk("hold.vld", {7'b0, out_valid}, 8'h00);

    vec("m3m6",   4'b1101, 4'b1010, 4'b0111, 4'b1000, 1'b1, 1'b1);
    vec("p7p7",   4'b0111, 4'b0111, 4'b1110, 4'b0111, 1'b1, 1'b0);
    vec("m1p1",   4'b1111, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1);
    vec("m8m1",   4'b1000, 4'b1111, 4'b0111, 4'b1000, 1'b1, 1'b1);
    vec("m8m8",   4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b1);
    vec("p7p1",   4'b0111, 4'b0001, 4'b1000, 4'b0111, 1'b1, 1'b0);
    vec("m8p7",   4'b1000, 4'b0111, 4'b1111, 4'b1111, 1'b0, 1'b0);
    vec("m2m3",   4'b1110, 4'b1101, 4'b1011, 4'b1011, 1'b0, 1'b1);
    vec("p3m5",   4'b0011, 4'b1011, 4'b1110, 4'b1110, 1'b0, 1'b0);
    vec("z0z0",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vec("m1m1",   4'b1111, 4'b1111, 4'b1110, 4'b1110, 1'b0, 1'b1);

    // Load a nonzero result, then reset together with in_valid.
    vec("p4p4",   4'b0100, 4'b0100, 4'b1000, 4'b0111, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b1000, 4'b1111);
    chk("rstv.sum", {4'b0, sum}, 8'h00);
    chk("rstv.ovf", {7'b0, overflow}, 8'h00);
    chk("rstv.cy",  {7'b0, carry_out}, 8'h00);
    chk("rstv.vld", {7'b0, out_valid}, 8'h00);

    step(1'b0, 1'b0, 4'b0111, 4'b0111);
    chk("post.sum", {4'b0, sum}, 8'h00);
    chk("post.vld", {7'b0, out_valid}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
